// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - ALU operation codes, branch flags and requester ids
package alu_arbiter_pkg;

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_SLL  = 6'd2;
  localparam logic [5:0] ALU_SLT  = 6'd3;
  localparam logic [5:0] ALU_SLTU = 6'd4;
  localparam logic [5:0] ALU_XOR  = 6'd5;
  localparam logic [5:0] ALU_SRL  = 6'd6;
  localparam logic [5:0] ALU_SRA  = 6'd7;
  localparam logic [5:0] ALU_OR   = 6'd8;
  localparam logic [5:0] ALU_AND  = 6'd9;
  localparam logic [5:0] ALU_BEQ  = 6'd10;
  localparam logic [5:0] ALU_BNE  = 6'd11;
  localparam logic [5:0] ALU_BLT  = 6'd12;
  localparam logic [5:0] ALU_BGE  = 6'd13;
  localparam logic [5:0] ALU_BLTU = 6'd14;
  localparam logic [5:0] ALU_BGEU = 6'd15;
  localparam logic [5:0] ALU_JAL  = 6'd16;
  localparam logic [5:0] ALU_JALR = 6'd17;
  localparam logic [5:0] ALU_LUI  = 6'd18;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic REQ_EXE = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  typedef struct packed {
    logic [5:0]  alucode;
    logic [31:0] op1;
    logic [31:0] op2;
  } alu_op_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational ALU; unknown codes yield result 0, br_taken 0
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [5:0]  alucode,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] alu_result,
  output logic        br_taken
);

  always_comb begin
    alu_result = '0;
    br_taken   = DISABLE;
    case (alucode)
      ALU_ADD:  alu_result = op1 + op2;
      ALU_SUB:  alu_result = op1 - op2;
      ALU_SLL:  alu_result = op1 << op2[4:0];
      ALU_SLT:  alu_result = {31'd0, $signed(op1) < $signed(op2)};
      ALU_SLTU: alu_result = {31'd0, op1 < op2};
      ALU_XOR:  alu_result = op1 ^ op2;
      ALU_SRL:  alu_result = op1 >> op2[4:0];
      ALU_SRA:  alu_result = $signed(op1) >>> op2[4:0];
      ALU_OR:   alu_result = op1 | op2;
      ALU_AND:  alu_result = op1 & op2;
      ALU_BEQ:  br_taken = (op1 == op2) ? ENABLE : DISABLE;
      ALU_BNE:  br_taken = (op1 != op2) ? ENABLE : DISABLE;
      ALU_BLT:  br_taken = ($signed(op1) < $signed(op2)) ? ENABLE : DISABLE;
      ALU_BGE:  br_taken = ($signed(op1) >= $signed(op2)) ? ENABLE : DISABLE;
      ALU_BLTU: br_taken = (op1 < op2) ? ENABLE : DISABLE;
      ALU_BGEU: br_taken = (op1 >= op2) ? ENABLE : DISABLE;
      // Link value: address of the instruction after the jump
      ALU_JAL, ALU_JALR: begin
        alu_result = op2 + 32'd4;
        br_taken   = ENABLE;
      end
      ALU_LUI:  alu_result = op2;
      default:  ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters with per-port response slots
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_alucode,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_alucode,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_br_taken,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_br_taken,
  output logic        prio,
  output logic        busy
);

  logic        free0, free1, acc0, acc1, sel;
  alu_op_t     op_sel;
  logic [31:0] alu_result;
  logic        br_taken;

  // Readiness ignores the port's own valid, so a requester may wait on ready safely
  assign free0      = !rsp0_valid || rsp0_ready;
  assign free1      = !rsp1_valid || rsp1_ready;
  assign req0_ready = !rst && free0 && (prio == REQ_EXE || !(req1_valid && free1));
  assign req1_ready = !rst && free1 && (prio == REQ_AUX || !(req0_valid && free0));
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;

  assign sel    = acc1 ? REQ_AUX : (acc0 ? REQ_EXE : prio);
  assign op_sel = (sel == REQ_AUX) ? alu_op_t'{req1_alucode, req1_op1, req1_op2}
                                   : alu_op_t'{req0_alucode, req0_op1, req0_op2};
  assign busy   = rsp0_valid || rsp1_valid;

  alu u_alu (
    .alucode    (op_sel.alucode),
    .op1        (op_sel.op1),
    .op2        (op_sel.op2),
    .alu_result (alu_result),
    .br_taken   (br_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid    <= 1'b0;
      rsp0_result   <= '0;
      rsp0_br_taken <= DISABLE;
      rsp1_valid    <= 1'b0;
      rsp1_result   <= '0;
      rsp1_br_taken <= DISABLE;
      prio          <= REQ_EXE;
    end else begin
      if (acc0) begin
        rsp0_valid    <= 1'b1;
        rsp0_result   <= alu_result;
        rsp0_br_taken <= br_taken;
      end else if (rsp0_ready) begin
        rsp0_valid <= 1'b0;
      end
      if (acc1) begin
        rsp1_valid    <= 1'b1;
        rsp1_result   <= alu_result;
        rsp1_br_taken <= br_taken;
      end else if (rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end
      if (acc0)      prio <= REQ_AUX;
      else if (acc1) prio <= REQ_EXE;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0]  req0_alucode, req1_alucode;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic        rsp0_valid, rsp0_ready, rsp0_br_taken;
  logic        rsp1_valid, rsp1_ready, rsp1_br_taken;
  logic [31:0] rsp0_result, rsp1_result;
  logic        prio, busy;

  int tests = 0;
  int fails = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_alucode(req0_alucode),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_alucode(req1_alucode),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_br_taken(rsp0_br_taken),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_br_taken(rsp1_br_taken),
    .prio(prio), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Reference ALU from instruction semantics: {br_taken, result}
  function automatic logic [32:0] ref_alu(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        t;
    int          sa, sb;
    r = 32'd0; t = 1'b0;
    sa = int'(a); sb = int'(b);
    case (code)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = 32'($signed(a) >>> b[4:0]);
      ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  r = a ^ b;
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      ALU_BEQ:  t = (a == b);
      ALU_BNE:  t = (a != b);
      ALU_BLT:  t = (sa < sb);
      ALU_BGE:  t = (sa >= sb);
      ALU_BLTU: t = (a < b);
      ALU_BGEU: t = (a >= b);
      ALU_JAL, ALU_JALR: begin r = b + 32'd4; t = 1'b1; end
      ALU_LUI:  r = b;
      default:  ;
    endcase
    return {t, r};
  endfunction

  function automatic logic [5:0] pick_code();
    if ($urandom_range(0, 9) == 0) return 6'h2a;
    return 6'($urandom_range(0, 18));
  endfunction

  function automatic logic [31:0] rnd_op();
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 40));
    return $urandom;
  endfunction

  vec_t vecs[$];
  int   g, n0, n1, win;
  logic m_valid[2];
  logic [31:0] m_res[2];
  logic m_br[2];
  logic m_prio;
  logic pend0, pend1, f0, f1, w0, w1, er0, er1;
  logic [32:0] r;

  initial begin
    vecs.push_back('{ALU_ADD,  32'd5,          32'd7,   32'd12,         1'b0});
    vecs.push_back('{ALU_SUB,  32'd10,         32'd4,   32'd6,          1'b0});
    vecs.push_back('{ALU_SUB,  32'd0,          32'd1,   32'hffffffff,   1'b0});
    vecs.push_back('{ALU_SLL,  32'd1,          32'd4,   32'd16,         1'b0});
    vecs.push_back('{ALU_SRL,  32'h80000000,   32'd4,   32'h08000000,   1'b0});
    vecs.push_back('{ALU_SRA,  32'h80000000,   32'd4,   32'hf8000000,   1'b0});
    vecs.push_back('{ALU_SLT,  32'hffffffff,   32'd1,   32'd1,          1'b0});
    vecs.push_back('{ALU_SLTU, 32'hffffffff,   32'd1,   32'd0,          1'b0});
    vecs.push_back('{ALU_XOR,  32'hff00ff00,   32'h0ff00ff0, 32'hf0f0f0f0, 1'b0});
    vecs.push_back('{ALU_OR,   32'h000000f0,   32'h0000000f, 32'h000000ff, 1'b0});
    vecs.push_back('{ALU_AND,  32'h0000ffff,   32'h00ff00ff, 32'h000000ff, 1'b0});
    vecs.push_back('{ALU_BEQ,  32'd3,          32'd3,   32'd0,          1'b1});
    vecs.push_back('{ALU_BNE,  32'd3,          32'd3,   32'd0,          1'b0});
    vecs.push_back('{ALU_BLT,  32'hfffffffe,   32'd1,   32'd0,          1'b1});
    vecs.push_back('{ALU_BGEU, 32'd1,          32'd2,   32'd0,          1'b0});
    vecs.push_back('{ALU_JAL,  32'd0,          32'h100, 32'h104,        1'b1});
    vecs.push_back('{ALU_JALR, 32'h55,         32'h200, 32'h204,        1'b1});
    vecs.push_back('{6'h3f,    32'd9,          32'd9,   32'd0,          1'b0});

    // Reset state; requests presented during reset must not be accepted
    rst = 1'b1;
    req0_valid = 1'b1; req0_alucode = ALU_ADD; req0_op1 = 32'd1; req0_op2 = 32'd1;
    req1_valid = 1'b1; req1_alucode = ALU_ADD; req1_op1 = 32'd2; req1_op2 = 32'd2;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick();
    #2;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_rsp0_result", rsp0_result, 0);
    check("rst_rsp1_br", rsp1_br_taken, 0);
    check("rst_prio", prio, 0);
    check("rst_busy", busy, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Table-driven single ops through port 0
    foreach (vecs[i]) begin
      req0_valid = 1'b1; req0_alucode = vecs[i].code;
      req0_op1 = vecs[i].a; req0_op2 = vecs[i].b;
      #2;
      check("vec_ready", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      #2;
      check("vec_valid", rsp0_valid, 1);
      check("vec_result", rsp0_result, vecs[i].res);
      check("vec_br", rsp0_br_taken, vecs[i].br);
      tick();
    end

    // Tie after reset
    do_reset();
    req0_valid = 1'b1; req0_alucode = ALU_BEQ; req0_op1 = 32'd3;  req0_op2 = 32'd3;
    req1_valid = 1'b1; req1_alucode = ALU_SUB; req1_op1 = 32'd10; req1_op2 = 32'd4;
    #2;
    check("tie_req0_ready", req0_ready, 1);
    check("tie_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #2;
    check("tie_rsp0_valid", rsp0_valid, 1);
    check("tie_rsp0_result", rsp0_result, 0);
    check("tie_rsp0_br", rsp0_br_taken, 1);
    check("tie_req1_ready2", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    #2;
    check("tie_rsp1_valid", rsp1_valid, 1);
    check("tie_rsp1_result", rsp1_result, 6);
    tick();

    // Fairness under continuous contention
    do_reset();
    n0 = 0; n1 = 0;
    req0_valid = 1'b1; req0_alucode = ALU_ADD; req0_op1 = 32'd100; req0_op2 = 32'd1;
    req1_valid = 1'b1; req1_alucode = ALU_ADD; req1_op1 = 32'd200; req1_op2 = 32'd1;
    for (int c = 0; c < 6; c++) begin
      #2;
      g = req0_ready ? 0 : (req1_ready ? 1 : 2);
      check("fair_grant", 32'(g), 32'(c % 2));
      tick();
      if (g == 0) begin
        check("fair_rsp0", rsp0_result, 32'(101 + n0));
        n0++;
        req0_op1 = 32'(100 + n0);
      end else if (g == 1) begin
        check("fair_rsp1", rsp1_result, 32'(201 + n1));
        n1++;
        req1_op1 = 32'(200 + n1);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("fair_count0", 32'(n0), 3);
    check("fair_count1", 32'(n1), 3);
    tick();

    // Back-pressure: slot 1 full and undrained
    do_reset();
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_alucode = ALU_SUB; req1_op1 = 32'd10; req1_op2 = 32'd4;
    #2;
    check("bp_fill_ready", req1_ready, 1);
    tick();
    req1_alucode = ALU_ADD; req1_op1 = 32'd1; req1_op2 = 32'd1;
    for (int j = 0; j < 4; j++) begin
      req0_valid = 1'b1; req0_alucode = ALU_ADD; req0_op1 = 32'(20 + j); req0_op2 = 32'd0;
      #2;
      check("bp_req1_ready", req1_ready, 0);
      check("bp_req0_ready", req0_ready, 1);
      tick();
      check("bp_rsp0_result", rsp0_result, 32'(20 + j));
      check("bp_rsp1_result", rsp1_result, 6);
      check("bp_rsp1_valid", rsp1_valid, 1);
    end

    // Drain and refill slot 0 in the same cycle
    req0_alucode = ALU_SLL; req0_op1 = 32'd1; req0_op2 = 32'd4;
    #2;
    check("dr_pre_valid", rsp0_valid, 1);
    check("dr_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0; rsp0_ready = 1'b0;
    #2;
    check("dr_rsp0_valid", rsp0_valid, 1);
    check("dr_rsp0_result", rsp0_result, 16);

    // Reset mid-operation
    rst = 1'b1;
    #1;
    check("mid_req0_ready", req0_ready, 0);
    check("mid_req1_ready", req1_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rsp0_valid", rsp0_valid, 0);
    check("mid_rsp1_valid", rsp1_valid, 0);
    check("mid_prio", prio, 0);
    req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick();

    // Randomized traffic against a transaction-level model
    do_reset();
    m_valid = '{1'b0, 1'b0}; m_res = '{32'd0, 32'd0}; m_br = '{1'b0, 1'b0}; m_prio = 1'b0;
    pend0 = 1'b0; pend1 = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!pend0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_alucode = pick_code(); req0_op1 = rnd_op();
        req0_op2 = ($urandom_range(0, 3) == 0) ? req0_op1 : rnd_op();
      end
      if (!pend1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_alucode = pick_code(); req1_op1 = rnd_op();
        req1_op2 = ($urandom_range(0, 3) == 0) ? req1_op1 : rnd_op();
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      #2;
      f0 = !m_valid[0] || rsp0_ready;
      f1 = !m_valid[1] || rsp1_ready;
      w0 = req0_valid && f0;
      w1 = req1_valid && f1;
      win = (w0 && w1) ? int'(m_prio) : (w0 ? 0 : (w1 ? 1 : -1));
      er0 = f0 && !(w1 && m_prio != 1'b0);
      er1 = f1 && !(w0 && m_prio != 1'b1);
      check("rnd_req0_ready", req0_ready, er0);
      check("rnd_req1_ready", req1_ready, er1);
      check("rnd_rsp0_valid", rsp0_valid, m_valid[0]);
      check("rnd_rsp1_valid", rsp1_valid, m_valid[1]);
      check("rnd_rsp0_result", rsp0_result, m_res[0]);
      check("rnd_rsp1_result", rsp1_result, m_res[1]);
      check("rnd_rsp0_br", rsp0_br_taken, m_br[0]);
      check("rnd_rsp1_br", rsp1_br_taken, m_br[1]);
      check("rnd_prio", prio, m_prio);
      check("rnd_busy", busy, m_valid[0] || m_valid[1]);
      if (win == 0) begin
        r = ref_alu(req0_alucode, req0_op1, req0_op2);
        m_valid[0] = 1'b1; m_res[0] = r[31:0]; m_br[0] = r[32];
      end else if (rsp0_ready) begin
        m_valid[0] = 1'b0;
      end
      if (win == 1) begin
        r = ref_alu(req1_alucode, req1_op1, req1_op2);
        m_valid[1] = 1'b1; m_res[1] = r[31:0]; m_br[1] = r[32];
      end else if (rsp1_ready) begin
        m_valid[1] = 1'b0;
      end
      if (win >= 0) m_prio = (win == 0);
      pend0 = req0_valid && (win != 0);
      pend1 = req1_valid && (win != 1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
